// File: rtl/rs_decode_stream_in.sv
// Receive side of the RS encoder stream: stores data lines and unpacks parity lines into per-block parity writes.
// Optional build macro RS_DECODE_STREAM_IN_ZERO_BLK_EN: a zero-block request goes straight to done.
package rs_encode_pkg;
    localparam int RS_DATA_BYTES = 256;
    localparam int RS_T          = 16;
    localparam int PARITY_W      = RS_T * 8;
endpackage

module rs_decode_stream_in
    import rs_encode_pkg::*;
#(
    parameter int NUM_REQ_BLOCKS   = 64,
    parameter int NUM_REQ_BLOCKS_W = 6,
    parameter int DATA_W           = 512
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    src_decoder_req_val,
    input  logic [NUM_REQ_BLOCKS_W-1:0]             src_decoder_req_num_blocks,
    output logic                                    decoder_src_req_rdy,
    input  logic                                    src_decoder_data_val,
    input  logic [DATA_W-1:0]                       src_decoder_data,
    output logic                                    decoder_src_data_rdy,
    output logic                                    data_mem_wr_val,
    output logic [NUM_REQ_BLOCKS_W+$clog2(RS_DATA_BYTES/(DATA_W/8))-1:0] data_mem_wr_addr,
    output logic [DATA_W-1:0]                       data_mem_wr_data,
    output logic                                    parity_mem_wr_val,
    output logic [NUM_REQ_BLOCKS_W-1:0]             parity_mem_wr_addr,
    output logic [PARITY_W-1:0]                     parity_mem_wr_data,
    output logic                                    decoder_done_val,
    output logic [NUM_REQ_BLOCKS_W-1:0]             decoder_done_num_blocks,
    input  logic                                    done_decoder_rdy
);

    localparam int DATA_BYTES       = DATA_W / 8;
    localparam int NUM_DATA_LINES   = RS_DATA_BYTES / DATA_BYTES;
    localparam int NUM_DATA_LINES_W = $clog2(NUM_DATA_LINES);
    localparam int PARITY_MEMS      = DATA_BYTES / RS_T;
    localparam int PARITY_SHIFT     = $clog2(PARITY_MEMS);
    localparam int SLOT_W           = (PARITY_SHIFT > 0) ? PARITY_SHIFT : 1;

    localparam logic [NUM_DATA_LINES_W-1:0] LAST_LINE = NUM_DATA_LINES_W'(NUM_DATA_LINES - 1);
    localparam logic [SLOT_W-1:0]           LAST_SLOT = SLOT_W'(PARITY_MEMS - 1);
    localparam logic [NUM_REQ_BLOCKS_W-1:0] ONE_BLK   = NUM_REQ_BLOCKS_W'(1);

    if (NUM_REQ_BLOCKS > (1 << NUM_REQ_BLOCKS_W)) begin : g_bad_blocks
        $error("NUM_REQ_BLOCKS does not fit in NUM_REQ_BLOCKS_W");
    end

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        UNPACK,
        DONE
    } state_t;

    state_t                        state;
    logic [NUM_REQ_BLOCKS_W-1:0]   num_blocks_reg;
    logic [NUM_REQ_BLOCKS_W-1:0]   block_cnt;
    logic [NUM_DATA_LINES_W-1:0]   line_cnt;
    logic [SLOT_W-1:0]             slot_cnt;
    logic [DATA_W-1:0]             par_line_reg;
    logic [NUM_REQ_BLOCKS_W-1:0]   last_blk;
    logic                          data_beat;

    assign last_blk  = num_blocks_reg - ONE_BLK;
    assign data_beat = src_decoder_data_val && decoder_src_data_rdy;

    assign decoder_src_req_rdy  = (state == IDLE);
    assign decoder_src_data_rdy = (state == DATA) || (state == PARITY);

    always_comb begin
        data_mem_wr_val         = data_beat && (state == DATA);
        data_mem_wr_addr        = '0;
        data_mem_wr_data        = '0;
        parity_mem_wr_val       = (state == UNPACK);
        parity_mem_wr_addr      = '0;
        parity_mem_wr_data      = '0;
        decoder_done_val        = (state == DONE);
        decoder_done_num_blocks = '0;
        if (data_mem_wr_val) begin
            data_mem_wr_addr = {block_cnt, line_cnt};
            data_mem_wr_data = src_decoder_data;
        end
        if (parity_mem_wr_val) begin
            parity_mem_wr_addr = block_cnt;
            parity_mem_wr_data = par_line_reg[DATA_W-1 -: PARITY_W];
        end
        if (decoder_done_val) begin
            decoder_done_num_blocks = num_blocks_reg;
        end
    end

    // The parity line is shifted left one slot per write, so the current slot is always the MSBs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            num_blocks_reg <= '0;
            block_cnt      <= '0;
            line_cnt       <= '0;
            slot_cnt       <= '0;
            par_line_reg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (src_decoder_req_val) begin
                        num_blocks_reg <= src_decoder_req_num_blocks;
                        block_cnt      <= '0;
                        line_cnt       <= '0;
                        slot_cnt       <= '0;
`ifdef RS_DECODE_STREAM_IN_ZERO_BLK_EN
                        if (src_decoder_req_num_blocks == '0) begin
                            state <= DONE;
                        end else begin
                            state <= DATA;
                        end
`else
                        state <= DATA;
`endif
                    end
                end
                DATA: begin
                    if (src_decoder_data_val) begin
                        if (line_cnt == LAST_LINE) begin
                            line_cnt <= '0;
                            if (block_cnt == last_blk) begin
                                block_cnt <= '0;
                                state     <= PARITY;
                            end else begin
                                block_cnt <= block_cnt + ONE_BLK;
                            end
                        end else begin
                            line_cnt <= line_cnt + NUM_DATA_LINES_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (src_decoder_data_val) begin
                        par_line_reg <= src_decoder_data;
                        slot_cnt     <= '0;
                        state        <= UNPACK;
                    end
                end
                UNPACK: begin
                    par_line_reg <= par_line_reg << PARITY_W;
                    block_cnt    <= block_cnt + ONE_BLK;
                    slot_cnt     <= slot_cnt + SLOT_W'(1);
                    if (block_cnt == last_blk) begin
                        state <= DONE;
                    end else if (slot_cnt == LAST_SLOT) begin
                        state <= PARITY;
                    end
                end
                DONE: begin
                    if (done_decoder_rdy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/rs_decode_stream_in.md
# rs_decode_stream_in

Receive-side counterpart of the RS encoder's output stream. It accepts one request's encoded stream: all data lines of every block, in block order, then the packed parity lines. Data lines are written into a block data memory. Each parity line is unpacked into per-block parity words for a parity memory. A done handshake then tells the downstream RS decoder that the request's blocks and parities are resident.

## Interface
Parameters:
- NUM_REQ_BLOCKS, -1: maximum blocks per request.
- NUM_REQ_BLOCKS_W, -1: width of block count/index.
- DATA_W, -1: stream line width in bits.
- Derived (localparam):
  - DATA_BYTES = DATA_W/8.
  - NUM_DATA_LINES = RS_DATA_BYTES/DATA_BYTES; NUM_DATA_LINES_W = $clog2(NUM_DATA_LINES).
  - PARITY_MEMS = DATA_BYTES/RS_T, a power of 2 ≥1; PARITY_SHIFT = $clog2(PARITY_MEMS).
  - PARITY_W, RS_DATA_BYTES and RS_T come from rs_encode_pkg.

Ports (clock/reset: one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- src_decoder_req_val  in  1  request metadata valid
- src_decoder_req_num_blocks  in  NUM_REQ_BLOCKS_W  blocks in request
- decoder_src_req_rdy  out  1  metadata accepted
- src_decoder_data_val  in  1  stream line valid
- src_decoder_data  in  DATA_W  stream line
- decoder_src_data_rdy  out  1  stream line accepted
- data_mem_wr_val  out  1  data memory write strobe
- data_mem_wr_addr  out  NUM_REQ_BLOCKS_W+NUM_DATA_LINES_W  {block, line}
- data_mem_wr_data  out  DATA_W  data line
- parity_mem_wr_val  out  1  parity memory write strobe
- parity_mem_wr_addr  out  NUM_REQ_BLOCKS_W  block index
- parity_mem_wr_data  out  PARITY_W  one block's parity
- decoder_done_val  out  1  request fully stored
- decoder_done_num_blocks  out  NUM_REQ_BLOCKS_W  block count of stored request
- done_decoder_rdy  in  1  downstream accepts done

## Operation
- FSM states are IDLE, DATA, PARITY, UNPACK and DONE. Each transfer completes when its val and rdy are both high in the same cycle.
- IDLE:
  - req_rdy=1.
  - On req transfer, register num_blocks and clear block_cnt, line_cnt, slot_cnt and par_addr. Go to DATA.
- DATA:
  - data_rdy=1.
  - Each beat gives data_mem_wr_val=1, addr={block_cnt,line_cnt}, data=src_decoder_data, all combinational from the beat.
  - line_cnt increments per beat. When line_cnt==NUM_DATA_LINES-1, line_cnt wraps to 0 and block_cnt increments.
  - A beat with both last line and block_cnt==num_blocks-1 clears block_cnt and goes to PARITY.
- PARITY:
  - data_rdy=1.
  - A beat captures the line into par_line_reg, clears slot_cnt and goes to UNPACK. No memory write happens on this beat.
- UNPACK:
  - data_rdy=0.
  - One parity write per cycle: addr=block_cnt, data=par_line_reg[DATA_W-1-slot_cnt*PARITY_W -: PARITY_W]. Slot 0 is the MSBs.
  - block_cnt and slot_cnt increment each cycle.
  - After the write with block_cnt==num_blocks-1, go to DONE. This applies even mid-line; the remaining pad slots are discarded.
  - Otherwise, after the write with slot_cnt==PARITY_MEMS-1, go to PARITY.
- DONE:
  - done_val=1 and done_num_blocks=num_blocks_reg.
  - On done transfer, go to IDLE.
- Parity lines consumed = ceil(num_blocks/PARITY_MEMS). Memories never backpressure.
- Widths and wrap:
  - block_cnt is NUM_REQ_BLOCKS_W bits and line_cnt is NUM_DATA_LINES_W bits; both wrap modulo 2^width.
  - Comparisons against num_blocks-1 are done at NUM_REQ_BLOCKS_W bits.

## Timing
- Reset:
  - Next state is IDLE and all registers clear.
  - In the cycle after the reset edge, req_rdy=1 and every other output is 0. Memory data/addr outputs read 0 when their val is 0.
  - Reset mid-request abandons it. Memory contents are not touched; there is no partial done.
- Data writes have zero latency from the accepted beat.
- Parity writes begin the cycle after the PARITY beat. One parity line costs 1+min(PARITY_MEMS, remaining blocks) cycles.
- req_rdy is 0 outside IDLE. data_rdy is 0 in IDLE, UNPACK and DONE.
- done_val holds until done_decoder_rdy; the DONE→IDLE transition and a new req cannot complete in the same cycle.
- For PARITY_MEMS=1, UNPACK lasts exactly 1 cycle per parity line.

## Configuration
- Macro: RS_DECODE_STREAM_IN_ZERO_BLK_EN.
- Defined: a req with num_blocks==0 goes IDLE→DONE directly. No data is consumed, no writes occur, and done_num_blocks=0.
- Undefined: num_blocks==0 is treated through normal wrap, i.e. 2^NUM_REQ_BLOCKS_W blocks.

## Test plan
The bench is built with DATA_W=512, NUM_DATA_LINES=4, PARITY_MEMS=4 and NUM_REQ_BLOCKS_W=6.
- num_blocks=4, 16 data beats plus 1 parity line, continuous valid:
  - 16 data writes at addrs 0..15.
  - 4 parity writes at addrs 0..3 with slots MSB-first.
  - done_num_blocks=4.
  - data_rdy low for 4 cycles after the parity beat.
- num_blocks=5: 20 data writes, 2 parity lines, 5 parity writes. The second line writes only slot 0 to addr 4, then DONE.
- Random val gaps on data and done_decoder_rdy held low for 10 cycles: write contents unchanged, done_val stays high, no new req accepted until done completes.
- rst asserted mid-DATA at beat 7, then a new request of 1 block: the next data write is at addr 0 and the prior state is gone.
- num_blocks=0:
  - With the macro: done in the cycle after req, zero writes.
  - Without the macro: 64 blocks, 256 data writes and 16 parity lines are consumed.
- num_blocks=63: last data addr {62,3}, last parity write addr 62 from slot 2 of line 15.
